hazard_sched: RTL and testbench
===============================

Name: hazard_sched

Overview:
- ID-stage hazard scheduler for the 5-stage RV32I pipeline.
- Consumes the decoded fields of the instruction in IF/ID and tracks the destination registers of in-flight instructions in an internal EX/MEM/WB shadow pipeline.
- Issues PC/IF-ID stall, IF/ID flush and ID/EX bubble controls.
- Supplies the registered EX-stage forwarding selects.

Parameters:
- XREGS, 32, number of architectural registers. Fixed at 32; register index width is 5.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  7  opcode of the IF/ID instruction.
- id_rs1  in  5  rs1 field.
- id_rs2  in  5  rs2 field.
- id_rd  in  5  rd field.
- ex_redirect  in  1  the instruction in EX is a taken branch or jump; the PC is redirected this cycle.
- stall_pc  out  1  hold the PC.
- stall_if_id  out  1  hold the IF/ID register.
- flush_if_id  out  1  clear IF/ID to a NOP.
- bubble_id_ex  out  1  load a NOP into ID/EX.
- fwd_a_sel  out  2  EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- fwd_b_sel  out  2  EX operand B source, same encoding.
- stall_cycles  out  CNT_W  count of cycles with stall_pc=1.

Behaviour:
- Reset: while rst_n=0 at a clock edge:
  - shadow slots EX/MEM/WB are invalidated;
  - fwd_a_sel and fwd_b_sel are set to 00;
  - stall_cycles is cleared to 0.
  - Stall, flush and bubble outputs are combinational. They are forced to 0 whenever rst_n=0 or slot state is reset.
- Register-use decode:
  - 0110011: uses rs1 and rs2; writes rd.
  - 0010011: uses rs1; writes rd.
  - 0000011 (load): uses rs1; writes rd; marked load.
  - 0100011: uses rs1 and rs2; no write.
  - 1100011: uses rs1 and rs2; no write.
  - 1100111: uses rs1; writes rd.
  - 1101111, 0110111, 0010111: no source use; write rd.
  - Any other opcode: no use, no write.
  - rd=x0 never writes. rs=x0 never hazards.
- Shadow slot contents: {valid, rd, is_load, writes}.
- Hazard condition (combinational): a used rs of a valid ID instruction matches the rd of a valid, writing slot. The set of slots checked depends on FORWARD_EN (see Optional Feature).
- Outputs on hazard: hazard -> stall_pc=1, stall_if_id=1, bubble_id_ex=1.
- Redirect priority: ex_redirect=1 -> flush_if_id=1, bubble_id_ex=1, stall_pc=0, stall_if_id=0.
  - Redirect overrides any hazard in the same cycle.
- Slot advance, every cycle:
  - WB <= MEM; MEM <= EX.
  - EX <= decoded ID instruction if id_valid and neither hazard nor redirect; otherwise EX <= invalid (bubble).
- Forwarding selects are registered alongside the EX slot and computed against the current EX and MEM slots.
  - For each operand: match with the EX slot -> 01 (EX-slot match has priority); else match with the MEM slot -> 10; else 00.
  - A bubble entering EX loads 00 into both selects.
- Write-back timing: the register file writes in the first half-cycle, so a WB-slot match never hazards.
- stall_cycles increments by 1 on each cycle with stall_pc=1 and wraps at 2^CNT_W-1 -> 0.
- Back-to-back hazards: the stall persists each cycle while the condition holds. There is no state machine beyond the slot shift, so the stall clears on the first cycle the condition is false.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined:
  - hazard = use matches an EX slot with is_load=1 only (load-use), giving a 1-cycle stall.
  - All other RAW dependencies are resolved by fwd_a_sel/fwd_b_sel.
- Undefined:
  - hazard = use matches either the EX or the MEM slot, giving up to 2 stall cycles.
  - fwd_a_sel and fwd_b_sel are constant 00, and the forwarding logic is not built.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_valid=1 -> all outputs 0, stall_cycles=0; first cycle after reset shows no stall for any fields.
- Load-use, forwarding enabled: `lw x5` then `add x6,x5,x7` -> exactly 1 cycle of stall_pc=1, stall_if_id=1, bubble_id_ex=1. The `add` then enters EX with fwd_a_sel=10. stall_cycles=1.
- ALU-ALU, forwarding enabled: `addi x3` then `sub x4,x1,x3` -> no stall; fwd_b_sel=01 when `sub` is in EX.
- No forwarding (macro undefined): `addi x3` then `sub x4,x3,x3` -> 2 stall cycles. fwd selects stay 00. stall_cycles=2.
- Redirect vs hazard: a hazard condition present in the same cycle as ex_redirect=1 -> flush_if_id=1, bubble_id_ex=1, stall_pc=0. The next cycle shows no residual stall.
- x0 and non-writers: `addi x0` then `add x1,x0,x0`, and `sw` then a dependent read of the store's rd field -> no stall and fwd selects 00.

Source files
------------

// File: rtl/hazard_sched.sv
// ID-stage hazard scheduler: stall/flush/bubble control and EX forwarding selects.
// Optional macro HAZARD_FORWARD_EN: load-use-only stalls plus registered forwarding selects.
module hazard_sched #(
    parameter int XREGS = 32,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [6:0]               id_opcode,
    input  logic [$clog2(XREGS)-1:0] id_rs1,
    input  logic [$clog2(XREGS)-1:0] id_rs2,
    input  logic [$clog2(XREGS)-1:0] id_rd,
    input  logic                     ex_redirect,
    output logic                     stall_pc,
    output logic                     stall_if_id,
    output logic                     flush_if_id,
    output logic                     bubble_id_ex,
    output logic [1:0]               fwd_a_sel,
    output logic [1:0]               fwd_b_sel,
    output logic [CNT_W-1:0]         stall_cycles
);
    localparam int RW = $clog2(XREGS);

    logic          w_use1, w_use2, w_wr, w_ld;
    logic          w_a_ex, w_b_ex, w_a_mem, w_b_mem;
    logic          w_hazard, w_redirect, w_issue;
    logic          r_ex_vld, r_ex_ld, r_ex_wr;
    logic          r_mem_vld, r_mem_ld, r_mem_wr;
    logic          r_wb_vld, r_wb_ld, r_wb_wr;
    logic [RW-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
    logic [CNT_W-1:0] r_cnt;
    logic          w_unused;

    always_comb begin
        w_use1 = 1'b0;
        w_use2 = 1'b0;
        w_wr   = 1'b0;
        w_ld   = 1'b0;
        case (id_opcode)
            7'b0110011: begin w_use1 = 1'b1; w_use2 = 1'b1; w_wr = 1'b1; end
            7'b0010011: begin w_use1 = 1'b1; w_wr = 1'b1; end
            7'b0000011: begin w_use1 = 1'b1; w_wr = 1'b1; w_ld = 1'b1; end
            7'b0100011,
            7'b1100011: begin w_use1 = 1'b1; w_use2 = 1'b1; end
            7'b1100111: begin w_use1 = 1'b1; w_wr = 1'b1; end
            7'b1101111,
            7'b0110111,
            7'b0010111: w_wr = 1'b1;
            default: ;
        endcase
        // x0 is hard-wired: it never produces or consumes a dependency.
        w_use1 = w_use1 && (id_rs1 != '0);
        w_use2 = w_use2 && (id_rs2 != '0);
        w_wr   = w_wr && (id_rd != '0);
    end

    assign w_a_ex  = w_use1 && r_ex_vld  && r_ex_wr  && (id_rs1 == r_ex_rd);
    assign w_b_ex  = w_use2 && r_ex_vld  && r_ex_wr  && (id_rs2 == r_ex_rd);
    assign w_a_mem = w_use1 && r_mem_vld && r_mem_wr && (id_rs1 == r_mem_rd);
    assign w_b_mem = w_use2 && r_mem_vld && r_mem_wr && (id_rs2 == r_mem_rd);

`ifdef HAZARD_FORWARD_EN
    assign w_hazard = rst_n && id_valid && r_ex_ld && (w_a_ex || w_b_ex);
`else
    assign w_hazard = rst_n && id_valid && (w_a_ex || w_b_ex || w_a_mem || w_b_mem);
`endif
    assign w_redirect = rst_n && ex_redirect;
    assign w_issue    = id_valid && !w_hazard && !w_redirect;

    assign stall_pc     = w_hazard && !w_redirect;
    assign stall_if_id  = w_hazard && !w_redirect;
    assign flush_if_id  = w_redirect;
    assign bubble_id_ex = w_hazard || w_redirect;
    assign stall_cycles = r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_vld  <= 1'b0;
            r_mem_vld <= 1'b0;
            r_wb_vld  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_ex_vld  <= w_issue;
            r_mem_vld <= r_ex_vld;
            r_wb_vld  <= r_mem_vld;
            if (stall_pc)
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Slot payload is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        r_ex_rd  <= id_rd;
        r_ex_ld  <= w_ld;
        r_ex_wr  <= w_wr;
        r_mem_rd <= r_ex_rd;
        r_mem_ld <= r_ex_ld;
        r_mem_wr <= r_ex_wr;
        r_wb_rd  <= r_mem_rd;
        r_wb_ld  <= r_mem_ld;
        r_wb_wr  <= r_mem_wr;
    end

`ifdef HAZARD_FORWARD_EN
    logic [1:0] r_fwd_a, r_fwd_b;

    always_ff @(posedge clk) begin
        if (!rst_n || !w_issue) begin
            r_fwd_a <= 2'b00;
            r_fwd_b <= 2'b00;
        end else begin
            r_fwd_a <= w_a_ex ? 2'b01 : (w_a_mem ? 2'b10 : 2'b00);
            r_fwd_b <= w_b_ex ? 2'b01 : (w_b_mem ? 2'b10 : 2'b00);
        end
    end

    assign fwd_a_sel = r_fwd_a;
    assign fwd_b_sel = r_fwd_b;
    assign w_unused  = ^{r_wb_vld, r_wb_rd, r_wb_ld, r_wb_wr, r_mem_ld};
`else
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
    // The WB slot and load flags are tracked but do not affect stalls here.
    assign w_unused  = ^{r_wb_vld, r_wb_rd, r_wb_ld, r_wb_wr, r_mem_ld, r_ex_ld};
`endif
endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched; expectations follow HAZARD_FORWARD_EN when defined.
module tb_hazard_sched;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        ex_redirect;
    logic        stall_pc, stall_if_id, flush_if_id, bubble_id_ex;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    hazard_sched #(.XREGS(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .bubble_id_ex(bubble_id_ex), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one ID instruction just after the rising edge, then move to the checking edge.
    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic redir);
        @(posedge clk);
        #1;
        id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        ex_redirect = redir;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 7'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic ctl(input string tag, input logic s, input logic f, input logic b);
        check({tag, ".stall_pc"}, stall_pc, s);
        check({tag, ".stall_if_id"}, stall_if_id, s);
        check({tag, ".flush"}, flush_if_id, f);
        check({tag, ".bubble"}, bubble_id_ex, b);
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b1; id_opcode = OP_R;
        id_rs1 = 5'd1; id_rs2 = 5'd1; id_rd = 5'd1; ex_redirect = 1'b1;
        // Reset held 2 cycles with a live instruction and redirect asserted.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ctl("rst", 1'b0, 1'b0, 1'b0);
            check("rst.fwd_a", fwd_a_sel, 0);
            check("rst.fwd_b", fwd_b_sel, 0);
            check("rst.cnt", stall_cycles, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, OP_R, 5'd1, 5'd1, 5'd1, 1'b0);
        ctl("post_rst", 1'b0, 1'b0, 1'b0);
        idle(3);

        // Load-use: lw x5 ; add x6,x5,x7
        drive(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b0);
        ctl("lu.c0", 1'b0, 1'b0, 1'b0);
        drive(1'b1, OP_R, 5'd5, 5'd7, 5'd6, 1'b0);
        ctl("lu.c1", 1'b1, 1'b0, 1'b1);
        drive(1'b1, OP_R, 5'd5, 5'd7, 5'd6, 1'b0);
`ifdef HAZARD_FORWARD_EN
        ctl("lu.c2", 1'b0, 1'b0, 1'b0);
        idle(1);
        check("lu.fwd_a", fwd_a_sel, 2);
        check("lu.fwd_b", fwd_b_sel, 0);
        check("lu.cnt", stall_cycles, 1);
`else
        ctl("lu.c2", 1'b1, 1'b0, 1'b1);
        drive(1'b1, OP_R, 5'd5, 5'd7, 5'd6, 1'b0);
        ctl("lu.c3", 1'b0, 1'b0, 1'b0);
        idle(1);
        check("lu.fwd_a", fwd_a_sel, 0);
        check("lu.fwd_b", fwd_b_sel, 0);
        check("lu.cnt", stall_cycles, 2);
`endif
        idle(3);

        // Invalid ID slot with matching fields never stalls.
        drive(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b0);
        drive(1'b0, OP_R, 5'd5, 5'd5, 5'd6, 1'b0);
        ctl("novalid", 1'b0, 1'b0, 1'b0);
        idle(3);

        // ALU-ALU dependency
        drive(1'b1, OP_I, 5'd1, 5'd0, 5'd3, 1'b0);
`ifdef HAZARD_FORWARD_EN
        drive(1'b1, OP_R, 5'd1, 5'd3, 5'd4, 1'b0);
        ctl("alu.c1", 1'b0, 1'b0, 1'b0);
        idle(1);
        check("alu.fwd_a", fwd_a_sel, 0);
        check("alu.fwd_b", fwd_b_sel, 1);
        check("alu.cnt", stall_cycles, 1);
`else
        drive(1'b1, OP_R, 5'd3, 5'd3, 5'd4, 1'b0);
        ctl("alu.c1", 1'b1, 1'b0, 1'b1);
        drive(1'b1, OP_R, 5'd3, 5'd3, 5'd4, 1'b0);
        ctl("alu.c2", 1'b1, 1'b0, 1'b1);
        drive(1'b1, OP_R, 5'd3, 5'd3, 5'd4, 1'b0);
        ctl("alu.c3", 1'b0, 1'b0, 1'b0);
        idle(1);
        check("alu.fwd_a", fwd_a_sel, 0);
        check("alu.fwd_b", fwd_b_sel, 0);
        check("alu.cnt", stall_cycles, 4);
`endif
        idle(3);

        // Redirect overrides a load-use hazard in the same cycle.
        drive(1'b1, OP_LD, 5'd1, 5'd0, 5'd3, 1'b0);
        drive(1'b1, OP_R, 5'd3, 5'd0, 5'd8, 1'b1);
        ctl("redir.c1", 1'b0, 1'b1, 1'b1);
        drive(1'b0, 7'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        ctl("redir.c2", 1'b0, 1'b0, 1'b0);
        check("redir.fwd_a", fwd_a_sel, 0);
        idle(3);

        // x0 destination and non-writing store
        drive(1'b1, OP_I, 5'd1, 5'd0, 5'd0, 1'b0);
        drive(1'b1, OP_R, 5'd0, 5'd0, 5'd1, 1'b0);
        ctl("x0", 1'b0, 1'b0, 1'b0);
        idle(1);
        check("x0.fwd_a", fwd_a_sel, 0);
        check("x0.fwd_b", fwd_b_sel, 0);
        idle(2);
        drive(1'b1, OP_ST, 5'd1, 5'd2, 5'd9, 1'b0);
        drive(1'b1, OP_R, 5'd9, 5'd9, 5'd10, 1'b0);
        ctl("sw", 1'b0, 1'b0, 1'b0);
        idle(1);
        check("sw.fwd_a", fwd_a_sel, 0);
        check("sw.fwd_b", fwd_b_sel, 0);
`ifdef HAZARD_FORWARD_EN
        check("final.cnt", stall_cycles, 1);
`else
        check("final.cnt", stall_cycles, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
